// File: rtl/a2d_resp_pkg.sv
// rtl/a2d_resp_pkg.sv - shared constants and state type for the A2D SPI responder
package a2d_resp_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous input bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/a2d_resp.sv
// rtl/a2d_resp.sv - SPI mode-0 responder emulating an A2D converter for the A2D_intf master
// Optional abort reporting (frame_err, abort counter) enabled by A2D_RESP_ERR_EN.
module a2d_resp
  import a2d_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  ch_req,
  input  logic [11:0] ch_data,
  output logic        cmd_vld
`ifdef A2D_RESP_ERR_EN
  ,
  output logic        frame_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic ss_s, sclk_s, mosi_s;
  logic ss_d, sclk_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_d   <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ss_d   <= ss_s;
      sclk_d <= sclk_s;
    end
  end

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  assign ss_fall   =  ss_d   & ~ss_s;
  assign ss_rise   = ~ss_d   &  ss_s;
  assign sclk_rise = ~sclk_d &  sclk_s;
  assign sclk_fall =  sclk_d & ~sclk_s;

  state_t               state, state_d;
  logic [15:0]          tx_shift;
  logic [CH_MSB:0]      rx_shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 rise_pend, rise_pend_d;
  logic                 load, rise_apply, fall_apply, done, abort;

  // A rise that coincides with frame start is deferred one cycle so the load wins.
  always_comb begin
    state_d     = state;
    rise_pend_d = 1'b0;
    load        = 1'b0;
    rise_apply  = 1'b0;
    fall_apply  = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_d     = SHIFT;
          load        = 1'b1;
          rise_pend_d = sclk_rise;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          done    = (bit_cnt == CNT_FULL);
          abort   = (bit_cnt != CNT_FULL);
        end else begin
          rise_apply = sclk_rise | rise_pend;
          fall_apply = sclk_fall & (bit_cnt != CNT_FULL);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rise_pend <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      ch_req    <= 3'h0;
      cmd_vld   <= 1'b0;
    end else begin
      state     <= state_d;
      rise_pend <= rise_pend_d;
      cmd_vld   <= done;
      if (load) begin
        tx_shift <= {4'h0, ch_data};
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (rise_apply) begin
        rx_shift <= {rx_shift[CH_MSB-1:0], mosi_s};
        if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (fall_apply) tx_shift <= {tx_shift[14:0], 1'b0};
      if (done) ch_req <= rx_shift[CH_MSB:CH_LSB];
    end
  end

  assign MISO = (state == SHIFT) & tx_shift[15];

`ifdef A2D_RESP_ERR_EN
  logic [7:0] abort_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      abort_cnt <= 8'h00;
    end else begin
      frame_err <= abort;
      if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_a2d_resp.sv
// tb/tb_a2d_resp.sv - randomized SPI-master bench for a2d_resp with a channel/data reference model
module tb_a2d_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [2:0]  ch_req;
  logic [11:0] ch_data;
  logic        cmd_vld;
`ifdef A2D_RESP_ERR_EN
  logic        frame_err;
`endif

  logic [11:0] mem [8];
  logic [2:0]  model_ch;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          vld_pulses = 0, vld_cycles = 0;
  int          err_pulses = 0, err_cycles = 0;
  logic        vld_prev = 1'b0, err_prev = 1'b0;

  always #5 clk = ~clk;

  assign ch_data = mem[ch_req];

  a2d_resp dut (
    .clk(clk),
    .rst_n(rst_n),
    .SS_n(SS_n),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .MISO(MISO),
    .ch_req(ch_req),
    .ch_data(ch_data),
    .cmd_vld(cmd_vld)
`ifdef A2D_RESP_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always @(negedge clk) begin
    if (cmd_vld === 1'b1 && vld_prev !== 1'b1) vld_pulses++;
    if (cmd_vld === 1'b1) vld_cycles++;
    vld_prev = cmd_vld;
`ifdef A2D_RESP_ERR_EN
    if (frame_err === 1'b1 && err_prev !== 1'b1) err_pulses++;
    if (frame_err === 1'b1) err_cycles++;
    err_prev = frame_err;
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master: mode 0, drives MOSI on SCLK fall, samples MISO at SCLK rise.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int half,
                           input int hi, input bit simul, output logic [15:0] rx);
    int first;
    rx = 16'h0;
    @(negedge clk);
    if (simul) begin
      MOSI = word[15];
      SS_n = 1'b0;
      SCLK = 1'b1;
      rx[15] = MISO;
      wait_clk(half);
      SCLK = 1'b0;
      first = 1;
    end else begin
      SS_n = 1'b0;
      wait_clk(6);
      first = 0;
    end
    for (int i = first; i < nbits; i++) begin
      MOSI = word[15-i];
      wait_clk(half);
      SCLK = 1'b1;
      rx[15-i] = MISO;
      wait_clk(half);
      SCLK = 1'b0;
    end
    wait_clk(half);
    SS_n = 1'b1;
    wait_clk(hi);
  endtask

  task automatic do_cmd(input logic [15:0] word, input int half, input int hi,
                        input bit simul, input string name);
    logic [15:0] exp_resp, got;
    int v0, c0;
    exp_resp = {4'h0, mem[model_ch]};
    v0 = vld_pulses;
    c0 = vld_cycles;
    spi_frame(word, 16, half, hi, simul, got);
    model_ch = word[13:11];
    n_checks++;
    if (got !== exp_resp) begin
      n_fail++;
      $display("FAIL %s resp: got %h expected %h", name, got, exp_resp);
    end
    n_checks++;
    if (ch_req !== model_ch) begin
      n_fail++;
      $display("FAIL %s ch_req: got %0d expected %0d", name, ch_req, model_ch);
    end
    n_checks++;
    if ((vld_pulses - v0) !== 1 || (vld_cycles - c0) !== 1) begin
      n_fail++;
      $display("FAIL %s cmd_vld: pulses %0d cycles %0d expected 1 and 1",
               name, vld_pulses - v0, vld_cycles - c0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
    model_ch = 3'h0;
    #3;
    n_checks++;
    if (MISO !== 1'b0 || ch_req !== 3'h0 || cmd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: MISO %b ch_req %0d cmd_vld %b expected 0 0 0", MISO, ch_req, cmd_vld);
    end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    n_checks++;
    if (MISO !== 1'b0 || ch_req !== 3'h0 || cmd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: MISO %b ch_req %0d cmd_vld %b expected 0 0 0", MISO, ch_req, cmd_vld);
    end
  endtask

  task automatic test_cmd_ch3;
    do_cmd(16'h1800, 4, 5, 1'b0, "cmd_ch3");
  endtask

  task automatic test_resp_abc;
    mem[3] = 12'hABC;
    do_cmd(16'h1800, 5, 5, 1'b0, "resp_abc");
  endtask

  task automatic test_abort;
    logic [15:0] got;
    int v0, e0, ec0;
    v0 = vld_cycles;
    e0 = err_pulses;
    ec0 = err_cycles;
    spi_frame(16'h2800, 8, 4, 6, 1'b0, got);
    n_checks++;
    if (ch_req !== model_ch) begin
      n_fail++;
      $display("FAIL abort ch_req: got %0d expected %0d", ch_req, model_ch);
    end
    n_checks++;
    if ((vld_cycles - v0) !== 0) begin
      n_fail++;
      $display("FAIL abort cmd_vld: cycles %0d expected 0", vld_cycles - v0);
    end
`ifdef A2D_RESP_ERR_EN
    n_checks++;
    if ((err_pulses - e0) !== 1 || (err_cycles - ec0) !== 1) begin
      n_fail++;
      $display("FAIL abort frame_err: pulses %0d cycles %0d expected 1 and 1",
               err_pulses - e0, err_cycles - ec0);
    end
`endif
    do_cmd(16'h3000, 4, 5, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back;
    do_cmd(16'h0800, 4, 4, 1'b0, "b2b_first");
    do_cmd(16'h2000, 4, 4, 1'b0, "b2b_second");
  endtask

  task automatic test_simul_start;
    do_cmd({2'b01, 3'd6, 11'h5A5}, 4, 5, 1'b1, "simul_start");
    do_cmd(16'h1000, 5, 5, 1'b0, "after_simul");
  endtask

  task automatic test_reset_mid;
    do_cmd(16'h3000, 4, 5, 1'b0, "pre_reset_ch6");
    @(negedge clk);
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 9; i++) begin
      MOSI = 1'(16'h2800 >> (15 - i));
      wait_clk(4);
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
    end
    wait_clk(2);
    #2;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b0;
    #1;
    n_checks++;
    if (MISO !== 1'b0 || ch_req !== 3'h0 || cmd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: MISO %b ch_req %0d cmd_vld %b expected 0 0 0", MISO, ch_req, cmd_vld);
    end
    wait_clk(2);
    rst_n = 1'b1;
    model_ch = 3'h0;
    wait_clk(4);
    do_cmd(16'h2800, 4, 5, 1'b0, "after_reset_mid");
  endtask

  task automatic test_random;
    logic [15:0] word;
    for (int n = 0; n < 12; n++) begin
      mem[$urandom_range(7, 0)] = 12'($urandom);
      word = 16'($urandom);
      do_cmd(word, $urandom_range(6, 4), $urandom_range(7, 4), 1'($urandom_range(1, 0)), "random");
    end
  endtask

  initial begin
    test_reset;
    test_cmd_ch3;
    test_resp_abc;
    test_abort;
    test_back_to_back;
    test_simul_start;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_resp.md
A2D_RESP -- requirements
Module: a2d_resp

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port SS_n, input, 1, SPI slave select from the A2D_intf master; asynchronous to clk.
REQ-004 SHALL have port SCLK, input, 1, SPI clock from the master; asynchronous to clk; mode 0.
REQ-005 SHALL have port MOSI, input, 1, SPI command data from the master.
REQ-006 SHALL have port MISO, output, 1, SPI response data to the master.
REQ-007 SHALL have port ch_req, output, 3, channel latched from the last complete command frame.
REQ-008 SHALL have port ch_data, input, 12, conversion value for ch_req; supplied by the environment and sampled at frame start.
REQ-009 SHALL have port cmd_vld, output, 1, one-clk pulse when ch_req is updated.
REQ-010 SHALL have port frame_err, output, 1, one-clk pulse on an aborted frame; present only with A2D_RESP_ERR_EN.

Function
REQ-011 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers, plus one extra flop for edge detect on SS_n and SCLK.
REQ-012 SHALL run a state machine with states IDLE and SHIFT; reset state IDLE.
REQ-013 IDLE->SHIFT on a synchronized SS_n fall; tx_shift (16b) loads {4'h0, ch_data}, bit count clears, rx_shift clears.
REQ-014 In SHIFT, on a synchronized SCLK rise, SHALL shift MOSI into rx_shift LSB and increment the bit count, saturating at 16.
REQ-015 In SHIFT, on a synchronized SCLK fall, SHALL shift tx_shift left and fill with 0; falls after bit count 16 are ignored.
REQ-016 MISO SHALL equal tx_shift[15] in SHIFT and 0 in IDLE.
REQ-017 SHIFT->IDLE on a synchronized SS_n rise, regardless of bit count.
REQ-018 On SS_n rise with bit count == 16, SHALL load ch_req from rx_shift[13:11] and pulse cmd_vld in the next clk.
REQ-019 On SS_n rise with bit count != 16 (abort), ch_req SHALL hold and cmd_vld SHALL stay 0.
REQ-020 The response frame SHALL always carry the data of the channel held in ch_req at its own SS_n fall, i.e. the channel from the previous command frame.
REQ-021 SCLK edges while in IDLE SHALL be ignored.
REQ-022 If SS_n fall and SCLK rise are detected in the same clk, SHALL load first and apply the rise in the following frame cycle.
REQ-023 Timing requirement on the master: SCLK half-period and SS_n high time >= 4 clk.
REQ-024 Timing guarantee: MISO bit 15 valid <= 4 clk after the SS_n pin falls.

Reset
REQ-025 rst_n low SHALL immediately force:
  - state IDLE
  - MISO 0, ch_req 3'h0, cmd_vld 0, frame_err 0
  - tx_shift, rx_shift, bit count 0
  - synchronizer flops to their idle levels: SS_n 1, SCLK 0, MOSI 0
REQ-026 Reset mid-frame SHALL discard the frame; the next frame after release SHALL return channel-0 data.

Configuration
REQ-027 With A2D_RESP_ERR_EN defined:
  - frame_err SHALL pulse one clk on each abort per REQ-019
  - an internal 8-bit saturating abort counter SHALL exist
REQ-028 Without A2D_RESP_ERR_EN, frame_err and the counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package a2d_resp_pkg SHALL hold:
  - FRAME_BITS = 16
  - CH_MSB = 13, CH_LSB = 11
  - the IDLE/SHIFT state enum
REQ-030 The synchronizers SHALL be instances of one sub-module, sync_2ff (one data bit, clk, rst_n, reset-level parameter).

Verification
REQ-031 Reset: rst_n low -> MISO=0, ch_req=0, cmd_vld=0, state IDLE.
REQ-032 Command frame with MOSI word 16'h1800 -> ch_req=3 after SS_n rise, cmd_vld high exactly 1 clk.
REQ-033 Response frame with ch_req=3 and ch_data=12'hABC at SS_n fall -> master receives 16'h0ABC.
REQ-034 Frame aborted after 8 SCLK rises -> ch_req unchanged, no cmd_vld, frame_err pulse 1 clk (with macro).
REQ-035 Back-to-back frames with SS_n high 4 clk, MOSI words 16'h0800 then 16'h2000 -> ch_req 1 then 4; second response carries ch_data for channel 1.
REQ-036 rst_n pulsed low at bit 9 of a command for channel 5 -> ch_req=0; next frame returns ch_data for channel 0.
